// File: rtl/mem_req_initiator.sv
// Command FIFO feeding a single-outstanding memory request FSM.
// Read responses are buffered in one register stage toward the pipeline.
module mem_req_initiator #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [31:0]  cmd_addr,
  input  logic [127:0] cmd_dat,
  input  logic [3:0]   cmd_len,
  input  logic         cmd_r_w,
  output logic [31:0]  req_addr,
  output logic [127:0] req_dat,
  output logic [3:0]   req_len,
  output logic         req_r_w,
  output logic         req_submit,
  input  logic         req_acc,
  input  logic [31:0]  res_addr,
  input  logic [127:0] res_dat,
  input  logic [3:0]   res_len,
  input  logic         res_rdy,
  output logic         res_read,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_addr,
  output logic [127:0] rsp_dat,
  output logic [3:0]   rsp_len,
  output logic         err_timeout,
  output logic         err_addr,
  output logic         err_stray
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = 1;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SUBMIT, WAIT_RES} state_t;

  state_t        state;
  logic [15:0]   wait_cnt;
  logic [31:0]   lat_addr;

  logic [31:0]   fifo_addr [DEPTH];
  logic [127:0]  fifo_dat  [DEPTH];
  logic [3:0]    fifo_len  [DEPTH];
  logic          fifo_r_w  [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          empty, full, push, pop, wait_done;

  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign wait_done = (wait_cnt == WAIT_LAST);
  // A timed-out submit drops the head just like an accepted one.
  assign pop       = (state == SUBMIT) && (req_acc || wait_done);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_idx] <= cmd_addr;
      fifo_dat[wr_idx]  <= cmd_dat;
      fifo_len[wr_idx]  <= cmd_len;
      fifo_r_w[wr_idx]  <= cmd_r_w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      lat_addr    <= '0;
      req_addr    <= '0;
      req_dat     <= '0;
      req_len     <= '0;
      req_r_w     <= 1'b0;
      req_submit  <= 1'b0;
      res_read    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_addr    <= '0;
      rsp_dat     <= '0;
      rsp_len     <= '0;
      err_timeout <= 1'b0;
      err_addr    <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      res_read <= 1'b0;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (res_rdy && state != WAIT_RES) err_stray <= 1'b1;

      case (state)
        IDLE: begin
          if (!empty && !rsp_valid) begin
            state      <= SUBMIT;
            wait_cnt   <= '0;
            req_submit <= 1'b1;
            req_addr   <= fifo_addr[rd_idx];
            req_dat    <= fifo_dat[rd_idx];
            req_len    <= fifo_len[rd_idx];
            req_r_w    <= fifo_r_w[rd_idx];
          end
        end
        SUBMIT: begin
          if (req_acc) begin
            req_submit <= 1'b0;
            lat_addr   <= req_addr;
            wait_cnt   <= '0;
            state      <= req_r_w ? WAIT_RES : IDLE;
          end else if (wait_done) begin
            req_submit  <= 1'b0;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        WAIT_RES: begin
          if (res_rdy) begin
            rsp_addr  <= res_addr;
            rsp_dat   <= res_dat;
            rsp_len   <= res_len;
            rsp_valid <= 1'b1;
            res_read  <= 1'b1;
            if (res_addr != lat_addr) err_addr <= 1'b1;
            state <= IDLE;
          end else if (wait_done) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Bench for mem_req_initiator: directed scenarios plus a randomized run
// checked against a queue-based transaction model.
module tb_mem_req_initiator;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [31:0]  cmd_addr;
  logic [127:0] cmd_dat;
  logic [3:0]   cmd_len;
  logic         cmd_r_w;
  logic [31:0]  req_addr;
  logic [127:0] req_dat;
  logic [3:0]   req_len;
  logic         req_r_w, req_submit, req_acc;
  logic [31:0]  res_addr;
  logic [127:0] res_dat;
  logic [3:0]   res_len;
  logic         res_rdy, res_read, rsp_valid, rsp_ready;
  logic [31:0]  rsp_addr;
  logic [127:0] rsp_dat;
  logic [3:0]   rsp_len;
  logic         err_timeout, err_addr, err_stray;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] dat;
    logic [3:0]   len;
    logic         r_w;
  } cmd_t;

  mem_req_initiator #(.DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_dat(cmd_dat), .cmd_len(cmd_len), .cmd_r_w(cmd_r_w),
    .req_addr(req_addr), .req_dat(req_dat), .req_len(req_len), .req_r_w(req_r_w),
    .req_submit(req_submit), .req_acc(req_acc),
    .res_addr(res_addr), .res_dat(res_dat), .res_len(res_len), .res_rdy(res_rdy),
    .res_read(res_read), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_dat(rsp_dat), .rsp_len(rsp_len),
    .err_timeout(err_timeout), .err_addr(err_addr), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cmd_valid = 0; cmd_addr = '0; cmd_dat = '0; cmd_len = '0; cmd_r_w = 0;
    req_acc = 0; res_rdy = 0; res_addr = '0; res_dat = '0; res_len = '0;
    rsp_ready = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [127:0] d,
                          input logic [3:0] l, input logic rw);
    cmd_valid = 1; cmd_addr = a; cmd_dat = d; cmd_len = l; cmd_r_w = rw;
    step();
    cmd_valid = 0;
  endtask

  task automatic accept();
    req_acc = 1;
    step();
    req_acc = 0;
  endtask

  task automatic wait_submit(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_submit) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    #1;
    checks++;
    if ({req_submit, res_read, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {req_submit, res_read, rsp_valid});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
    checks++;
    if ({req_addr, req_len, rsp_addr, rsp_len} !== '0 || req_dat !== '0 || rsp_dat !== '0) begin
      errors++; $display("FAIL reset_fields: req_addr %h rsp_addr %h expected 0", req_addr, rsp_addr);
    end
    checks++;
    if ({err_timeout, err_addr, err_stray} !== 3'b000) begin
      errors++; $display("FAIL reset_errs: got %b expected 000", {err_timeout, err_addr, err_stray});
    end
    do_reset();
    step();
    checks++;
    if (req_submit !== 1'b0) begin
      errors++; $display("FAIL reset_idle: req_submit %b expected 0", req_submit);
    end
  endtask

  task automatic test_read_basic();
    do_reset();
    push_cmd(32'h0000_1000, '0, 4'd4, 1'b1);
    checks++;
    if (req_submit !== 1'b0) begin
      errors++; $display("FAIL latency_early: req_submit %b expected 0", req_submit);
    end
    step();
    checks++;
    if (req_submit !== 1'b1 || req_addr !== 32'h1000 || req_len !== 4'd4 || req_r_w !== 1'b1) begin
      errors++; $display("FAIL latency_submit: submit %b addr %h len %h rw %b expected 1 1000 4 1",
                         req_submit, req_addr, req_len, req_r_w);
    end
    step(); step();
    checks++;
    if (req_submit !== 1'b1 || req_addr !== 32'h1000) begin
      errors++; $display("FAIL req_hold: submit %b addr %h expected 1 1000", req_submit, req_addr);
    end
    accept();
    checks++;
    if (req_submit !== 1'b0) begin
      errors++; $display("FAIL req_drop: req_submit %b expected 0", req_submit);
    end
    step(); step();
    checks++;
    if (res_read !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL wait_res: res_read %b rsp_valid %b expected 0 0", res_read, rsp_valid);
    end
    res_rdy = 1; res_addr = 32'h1000; res_dat = {16{8'hAA}}; res_len = 4'd4;
    step();
    res_rdy = 0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_addr !== 32'h1000 || rsp_dat !== {16{8'hAA}} || rsp_len !== 4'd4) begin
      errors++; $display("FAIL rsp_capture: valid %b addr %h dat %h len %h", rsp_valid, rsp_addr, rsp_dat, rsp_len);
    end
    checks++;
    if (res_read !== 1'b1) begin
      errors++; $display("FAIL res_read_pulse: got %b expected 1", res_read);
    end
    step();
    checks++;
    if (res_read !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL res_read_once: res_read %b rsp_valid %b expected 0 1", res_read, rsp_valid);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rsp_clear: rsp_valid %b expected 0", rsp_valid);
    end
    checks++;
    if ({err_timeout, err_addr, err_stray} !== 3'b000) begin
      errors++; $display("FAIL read_no_err: got %b expected 000", {err_timeout, err_addr, err_stray});
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) push_cmd(32'h100 * (i + 1), '0, 4'd1, 1'b0);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL full_after_4: cmd_ready %b expected 0", cmd_ready);
    end
    cmd_valid = 1; cmd_addr = 32'h500; cmd_r_w = 0;
    step(); step(); step();
    checks++;
    if (cmd_ready !== 1'b0 || req_submit !== 1'b1 || req_addr !== 32'h100) begin
      errors++; $display("FAIL full_hold: ready %b submit %b addr %h expected 0 1 100",
                         cmd_ready, req_submit, req_addr);
    end
    accept();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_pop: cmd_ready %b expected 1", cmd_ready);
    end
    cmd_valid = 1;
    step();
    cmd_valid = 0;
    for (int k = 2; k <= 5; k++) begin
      wait_submit(ok);
      checks++;
      if (!ok || req_addr !== 32'h100 * k) begin
        errors++; $display("FAIL fifo_order_%0d: submit %b addr %h expected %h", k, ok, req_addr, 32'h100 * k);
      end
      accept();
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    push_cmd(32'h3000, '0, 4'd2, 1'b0);
    push_cmd(32'h3100, '0, 4'd2, 1'b0);
    wait_submit(ok);
    repeat (TO - 1) step();
    checks++;
    if (req_submit !== 1'b1 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_early: submit %b err_timeout %b expected 1 0", req_submit, err_timeout);
    end
    step();
    checks++;
    if (req_submit !== 1'b0 || err_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_fire: submit %b err_timeout %b expected 0 1", req_submit, err_timeout);
    end
    wait_submit(ok);
    checks++;
    if (!ok || req_addr !== 32'h3100) begin
      errors++; $display("FAIL timeout_next: submit %b addr %h expected 1 3100", ok, req_addr);
    end
    accept();
    step();
    checks++;
    if (err_timeout !== 1'b1 || req_submit !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky: err_timeout %b submit %b expected 1 0", err_timeout, req_submit);
    end
    // Accept arriving on the last allowed cycle must win over the timeout.
    do_reset();
    push_cmd(32'h3200, '0, 4'd1, 1'b0);
    wait_submit(ok);
    repeat (TO - 1) step();
    accept();
    checks++;
    if (err_timeout !== 1'b0 || req_submit !== 1'b0) begin
      errors++; $display("FAIL acc_beats_timeout: err_timeout %b submit %b expected 0 0", err_timeout, req_submit);
    end
    step(); step();
    checks++;
    if (req_submit !== 1'b0) begin
      errors++; $display("FAIL acc_popped: req_submit %b expected 0", req_submit);
    end
  endtask

  task automatic test_stray_and_addr();
    bit ok;
    logic [127:0] d;
    do_reset();
    res_rdy = 1; res_addr = 32'h9999;
    step();
    res_rdy = 0;
    checks++;
    if (err_stray !== 1'b1 || res_read !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stray_idle: err_stray %b res_read %b rsp_valid %b expected 1 0 0",
                         err_stray, res_read, rsp_valid);
    end
    push_cmd(32'h1000, '0, 4'd3, 1'b1);
    wait_submit(ok);
    accept();
    d = {$urandom, $urandom, $urandom, $urandom};
    res_rdy = 1; res_addr = 32'h2000; res_dat = d; res_len = 4'd3;
    step();
    res_rdy = 0;
    checks++;
    if (err_addr !== 1'b1 || rsp_valid !== 1'b1 || rsp_dat !== d || rsp_addr !== 32'h2000) begin
      errors++; $display("FAIL addr_mismatch: err_addr %b valid %b dat %h addr %h expected 1 1 %h 2000",
                         err_addr, rsp_valid, rsp_dat, rsp_addr, d);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
  endtask

  task automatic test_rsp_backpressure();
    bit ok, seen;
    do_reset();
    push_cmd(32'h4000, '0, 4'd1, 1'b1);
    push_cmd(32'h4100, '0, 4'd1, 1'b1);
    wait_submit(ok);
    accept();
    res_rdy = 1; res_addr = 32'h4000; res_dat = '1; res_len = 4'd1;
    step();
    res_rdy = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_submit) seen = 1;
      step();
    end
    checks++;
    if (seen !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_block: submit_seen %b rsp_valid %b expected 0 1", seen, rsp_valid);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: rsp_valid %b expected 0", rsp_valid);
    end
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (req_submit) begin seen = 1; break; end
    end
    checks++;
    if (seen !== 1'b1 || req_addr !== 32'h4100) begin
      errors++; $display("FAIL bp_resume: submit %b addr %h expected 1 4100", seen, req_addr);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    res_rdy = 1;
    step();
    res_rdy = 0;
    push_cmd(32'h5000, '0, 4'd2, 1'b1);
    push_cmd(32'h5100, '0, 4'd2, 1'b0);
    wait_submit(ok);
    accept();
    #2;
    rst = 0;
    #1;
    checks++;
    if (req_addr !== 32'h0 || req_submit !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || res_read !== 1'b0) begin
      errors++; $display("FAIL async_reset_out: addr %h submit %b ready %b valid %b res_read %b",
                         req_addr, req_submit, cmd_ready, rsp_valid, res_read);
    end
    checks++;
    if ({err_timeout, err_addr, err_stray} !== 3'b000) begin
      errors++; $display("FAIL async_reset_err: got %b expected 000", {err_timeout, err_addr, err_stray});
    end
    #1;
    rst = 1;
    step();
    res_rdy = 1; res_addr = 32'h5000; res_dat = '1;
    step();
    res_rdy = 0;
    checks++;
    if (err_stray !== 1'b1 || res_read !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_stray: err_stray %b res_read %b rsp_valid %b expected 1 0 0",
                         err_stray, res_read, rsp_valid);
    end
    step(); step();
    checks++;
    if (req_submit !== 1'b0) begin
      errors++; $display("FAIL fifo_discarded: req_submit %b expected 0", req_submit);
    end
  endtask

  task automatic test_random();
    localparam int N = 40;
    cmd_t cmds[$];
    cmd_t iss_q[$];
    cmd_t rsp_q[$];
    cmd_t c, pend_c, r;
    bit pend, prev_res;
    int sent, pend_dly, sub_wait;
    do_reset();
    for (int i = 0; i < N; i++) begin
      c.addr = $urandom; c.dat = {$urandom, $urandom, $urandom, $urandom};
      c.len = 4'($urandom_range(0, 15)); c.r_w = 1'($urandom_range(0, 1));
      cmds.push_back(c);
    end
    pend = 0; prev_res = 0; sent = 0; pend_dly = 0; sub_wait = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      checks++;
      if (res_read !== prev_res) begin
        errors++; $display("FAIL rnd_res_read: cycle %0d got %b expected %b", cyc, res_read, prev_res);
      end
      checks++;
      if (rsp_valid !== (rsp_q.size() != 0)) begin
        errors++; $display("FAIL rnd_rsp_valid: cycle %0d got %b expected %b", cyc, rsp_valid, rsp_q.size() != 0);
      end
      if (rsp_valid && rsp_q.size() != 0) begin
        checks++;
        if (rsp_addr !== rsp_q[0].addr || rsp_dat !== rsp_q[0].dat || rsp_len !== rsp_q[0].len) begin
          errors++; $display("FAIL rnd_rsp: addr %h dat %h len %h expected %h %h %h",
                             rsp_addr, rsp_dat, rsp_len, rsp_q[0].addr, rsp_q[0].dat, rsp_q[0].len);
        end
      end
      if (req_submit) begin
        checks++;
        if (iss_q.size() == 0) begin
          errors++; $display("FAIL rnd_req_unexpected: addr %h with no queued command", req_addr);
        end else if (req_addr !== iss_q[0].addr || req_dat !== iss_q[0].dat ||
                     req_len !== iss_q[0].len || req_r_w !== iss_q[0].r_w) begin
          errors++; $display("FAIL rnd_req: addr %h len %h rw %b expected %h %h %b",
                             req_addr, req_len, req_r_w, iss_q[0].addr, iss_q[0].len, iss_q[0].r_w);
        end
      end
      if (sent == N && iss_q.size() == 0 && !pend && rsp_q.size() == 0) break;

      cmd_valid = (sent < N) && ($urandom_range(0, 2) != 0);
      if (cmd_valid) begin
        cmd_addr = cmds[sent].addr; cmd_dat = cmds[sent].dat;
        cmd_len = cmds[sent].len; cmd_r_w = cmds[sent].r_w;
        if (cmd_ready) begin
          iss_q.push_back(cmds[sent]);
          sent++;
        end
      end

      res_rdy = 0;
      if (pend) begin
        if (pend_dly == 0) begin
          r.addr = pend_c.addr; r.dat = {$urandom, $urandom, $urandom, $urandom};
          r.len = 4'($urandom_range(0, 15)); r.r_w = 1'b1;
          res_rdy = 1; res_addr = r.addr; res_dat = r.dat; res_len = r.len;
          rsp_q.push_back(r);
          pend = 0;
        end else begin
          pend_dly--;
        end
      end
      prev_res = res_rdy;

      req_acc = 0;
      if (req_submit && iss_q.size() != 0) begin
        sub_wait++;
        if (sub_wait >= 8 || $urandom_range(0, 2) == 0) begin
          req_acc = 1;
          sub_wait = 0;
          c = iss_q.pop_front();
          if (c.r_w) begin
            pend = 1; pend_c = c; pend_dly = $urandom_range(0, 3);
          end
        end
      end

      rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_ready && rsp_valid && rsp_q.size() != 0) void'(rsp_q.pop_front());
      step();
    end
    clear_inputs();
    checks++;
    if (sent != N || iss_q.size() != 0 || rsp_q.size() != 0 || pend) begin
      errors++; $display("FAIL rnd_complete: sent %0d of %0d, queued %0d, responses %0d",
                         sent, N, iss_q.size(), rsp_q.size());
    end
    checks++;
    if ({err_timeout, err_addr, err_stray} !== 3'b000) begin
      errors++; $display("FAIL rnd_errs: got %b expected 000", {err_timeout, err_addr, err_stray});
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_fifo_full();
    test_timeout();
    test_stray_and_addr();
    test_rsp_backpressure();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_req_initiator.md
MEM_REQ_INITIATOR -- requirements
Module: mem_req_initiator

Interface
REQ-001 Parameter DEPTH, 4, command FIFO entries (power of two, at least 2).
REQ-002 Parameter TIMEOUT, 1024, cycles allowed waiting for req_acc or res_rdy before abort.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  pipeline offers a memory command.
REQ-006 cmd_ready  out  1  FIFO can take a command.
REQ-007 cmd_addr / cmd_dat / cmd_len / cmd_r_w  in  32/128/4/1  command fields; r_w 1 = read, 0 = write.
REQ-008 req_addr / req_dat / req_len / req_r_w  out  32/128/4/1  request fields to the memory access controller.
REQ-009 req_submit  out  1  request offered to the controller.
REQ-010 req_acc  in  1  controller accepted the request.
REQ-011 res_addr / res_dat / res_len  in  32/128/4  read response fields from the controller.
REQ-012 res_rdy  in  1  controller response valid.
REQ-013 res_read  out  1  one-cycle pulse: response consumed.
REQ-014 rsp_valid / rsp_ready  out/in  1/1  read data handshake to the pipeline.
REQ-015 rsp_addr / rsp_dat / rsp_len  out  32/128/4  registered read response.
REQ-016 err_timeout / err_addr / err_stray  out  1/1/1  sticky error flags.

Function
REQ-017 Command FIFO push when cmd_valid && cmd_ready; cmd_ready = !full, with no same-cycle push-on-pop while full.
REQ-018 FSM states: IDLE, SUBMIT, WAIT_RES.
REQ-019 IDLE: if FIFO not empty and rsp_valid low, go to SUBMIT next cycle; otherwise stay.
REQ-020 SUBMIT: req_submit = 1; req_* driven from the FIFO head and held stable until req_acc.
REQ-021 SUBMIT with req_acc: pop the FIFO head and latch its address; on a read go to WAIT_RES; on a write go to IDLE. Writes produce no pipeline response.
REQ-022 WAIT_RES with res_rdy:
  - capture res_* into the rsp registers and set rsp_valid;
  - pulse res_read for exactly 1 cycle (the cycle after res_rdy is sampled);
  - go to IDLE.
REQ-023 If res_addr differs from the latched address at capture, set err_addr; data is still delivered.
REQ-024 rsp_valid holds until rsp_ready is sampled high, then clears. At most one response is buffered, which blocks new issue per REQ-019.
REQ-025 res_rdy sampled high outside WAIT_RES: ignore the data, set err_stray, do not pulse res_read.
REQ-026 16-bit wait counter clears on entry to SUBMIT or WAIT_RES and increments each cycle in those states.
REQ-027 When the counter reaches TIMEOUT-1 without req_acc or res_rdy:
  - set err_timeout;
  - in SUBMIT, pop and drop the head;
  - return to IDLE.
REQ-028 req_acc and a timeout in the same cycle: req_acc wins and no error is raised. The same rule applies to res_rdy.
REQ-029 req_acc outside SUBMIT is ignored.
REQ-030 Latency: a command pushed into an empty, idle block at edge k raises req_submit after edge k+1. A read completing at edge j has rsp_valid high after edge j.
REQ-031 One request is in flight at a time; order is strictly FIFO.

Reset
REQ-032 rst low asynchronously forces:
  - state IDLE and FIFO empty;
  - req_submit 0, res_read 0, rsp_valid 0;
  - req_*, rsp_* and wait counter 0;
  - all error flags 0;
  - cmd_ready 1.
REQ-033 Reset mid-transaction discards the in-flight request and FIFO contents. After reset deasserts, a subsequent res_rdy sets err_stray.
REQ-034 Error flags clear only on reset.

Verification
REQ-035 Read 0x0000_1000, len 4; req_acc 3 cycles later; res_rdy with dat 0xAA.. 2 cycles later -> one res_read pulse, rsp_valid with addr 0x1000 and dat 0xAA.., no errors.
REQ-036 Push 5 commands back-to-back with DEPTH=4 and no req_acc -> cmd_ready low after 4 pushes; 5th held until the first pop; order preserved on req_addr.
REQ-037 Write with req_acc held low for TIMEOUT cycles -> err_timeout=1; FIFO head dropped; next command submitted.
REQ-038 res_rdy in IDLE -> err_stray=1, res_read stays 0; read response with res_addr 0x2000 vs issued 0x1000 -> err_addr=1 and data delivered.
REQ-039 rsp_ready held low with a second read queued -> no req_submit until rsp_ready pulses; then submit within 2 cycles.
REQ-040 rst low during WAIT_RES -> all outputs at reset values immediately (asynchronously); post-reset res_rdy -> err_stray=1.
